// File: rtl/riscv_pkg.sv
// Shared dBus definitions: byte-lane size masks, the data-SRAM slave state type,
// and small lane helpers used by the slave.
package riscv_pkg;

  localparam logic [3:0] SZ_BYTE = 4'b0001;
  localparam logic [3:0] SZ_HALF = 4'b0011;
  localparam logic [3:0] SZ_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_sram_state_e;

  // Byte enables for a low-justified size mask moved to the addressed lane; carry-out is dropped.
  function automatic logic [3:0] lane_enable(input logic [3:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = size << off;
    return be;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic size_legal(input logic [3:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);
  endfunction

endpackage

// File: rtl/dbus_sram_array.sv
// Word-organised storage for the dBus data SRAM: per-byte write enables and a
// registered (synchronous) read port sharing a single index.
module dbus_sram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we[lane]) begin
        mem[idx][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dbus_sram_slave.sv
// dBus data-memory slave: one outstanding command, fixed wait-state latency, byte-lane stores/loads.
// Optional access checking is enabled by defining DBUS_SRAM_ERR_CHECK_EN.
module dbus_sram_slave
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic [31:0] dBus_cmd_payload_addr,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [3:0]  dBus_cmd_payload_size,
  input  logic        dBus_cmd_payload_wr,
  output logic [31:0] dBus_rsp_data,
  output logic        dBus_rsp_valid,
  output logic        dBus_rsp_error
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dbus_sram_state_e state, next_state;

  logic             ready_q;
  logic [3:0]       wait_cnt;
  logic [31:0]      rsp_data_hold;
  logic             accept;
  logic             enter_resp;

  logic [31:0]      cmd_rel;
  logic [IDX_W-1:0] cmd_idx;
  logic [1:0]       cmd_off;
  logic [3:0]       cmd_be;
  logic [31:0]      cmd_wdata;
  logic             cmd_err;

  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_off;
  logic [3:0]       lat_be;
  logic [31:0]      lat_wdata;
  logic             lat_wr;
  logic             lat_err;

  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic             acc_wr;
  logic             acc_err;
  logic [3:0]       mem_we;
  logic             mem_re;
  logic [31:0]      mem_rdata;
  logic [31:0]      load_data;

  assign accept = dBus_cmd_valid & ready_q;

  assign cmd_rel   = dBus_cmd_payload_addr - BASE_ADDR;
  assign cmd_idx   = cmd_rel[IDX_W+1:2];
  assign cmd_off   = cmd_rel[1:0];
  assign cmd_be    = lane_enable(dBus_cmd_payload_size, cmd_off);
  assign cmd_wdata = dBus_cmd_payload_data << {cmd_off, 3'b000};

`ifdef DBUS_SRAM_ERR_CHECK_EN
  assign cmd_err = (cmd_rel[31:IDX_W+2] != '0)
                 | !size_legal(dBus_cmd_payload_size)
                 | ((dBus_cmd_payload_size == SZ_HALF) && cmd_off[0])
                 | ((dBus_cmd_payload_size == SZ_WORD) && (cmd_off != 2'b00));
`else
  logic unused_rel_hi;
  assign unused_rel_hi = ^cmd_rel[31:IDX_W+2];
  assign cmd_err       = 1'b0;
`endif

  always_comb begin
    next_state = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            next_state = RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the array is touched on the accept edge, so use the live command.
  always_comb begin
    mem_idx   = lat_idx;
    mem_be    = lat_be;
    mem_wdata = lat_wdata;
    acc_wr    = lat_wr;
    acc_err   = lat_err;
    if (state == IDLE) begin
      mem_idx   = cmd_idx;
      mem_be    = cmd_be;
      mem_wdata = cmd_wdata;
      acc_wr    = dBus_cmd_payload_wr;
      acc_err   = cmd_err;
    end
  end

  assign mem_we = (enter_resp && acc_wr && !acc_err && !rst) ? mem_be : 4'b0000;
  assign mem_re = enter_resp && !acc_wr && !rst;

  dbus_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .idx  (mem_idx),
    .wdata(mem_wdata),
    .re   (mem_re),
    .rdata(mem_rdata)
  );

  always_comb begin
    load_data = '0;
    if (!lat_wr && !lat_err) begin
      load_data = (mem_rdata & lane_mask(lat_be)) >> {lat_off, 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ready_q       <= 1'b1;
      wait_cnt      <= 4'd0;
      rsp_data_hold <= '0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == IDLE);
      if (accept) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == RESP) begin
        rsp_data_hold <= load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_idx   <= cmd_idx;
      lat_off   <= cmd_off;
      lat_be    <= cmd_be;
      lat_wdata <= cmd_wdata;
      lat_wr    <= dBus_cmd_payload_wr;
      lat_err   <= cmd_err;
    end
  end

  assign dBus_cmd_ready = ready_q;
  assign dBus_rsp_valid = (state == RESP);
  assign dBus_rsp_data  = (state == RESP) ? load_data : rsp_data_hold;

`ifdef DBUS_SRAM_ERR_CHECK_EN
  logic rsp_error_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_error_hold <= 1'b0;
    end else if (state == RESP) begin
      rsp_error_hold <= lat_err;
    end
  end

  assign dBus_rsp_error = (state == RESP) ? lat_err : rsp_error_hold;
`else
  assign dBus_rsp_error = 1'b0;
`endif

endmodule
